// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// {ext, brk, code} events and buffers them in a FIFO popped by the host.
module ps2_kbd_event_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             nextdata_n,
    output logic [7:0]       data,
    output logic             ext,
    output logic             brk,
    output logic             ready,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] key_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} dec_state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   fall, din;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign din  = dat_sync[SYNC_STAGES-1];

    // sr holds start..parity; the stop bit is taken live from din on the 11th edge
    logic [9:0]    sr;
    logic [3:0]    bitcnt;
    logic [TW-1:0] idle_cnt;
    logic          frame_last, frame_ok;
    logic [7:0]    rx_byte;

    assign frame_last = fall && (bitcnt == 4'd10);
    assign frame_ok   = frame_last && !sr[0] && din && (^sr[9:1]);
    assign rx_byte    = sr[8:1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sr        <= '0;
            bitcnt    <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_last && !frame_ok;
            if (fall) begin
                sr       <= {din, sr[9:1]};
                bitcnt   <= frame_last ? 4'd0 : bitcnt + 4'd1;
                idle_cnt <= '0;
            end else if (bitcnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bitcnt   <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    dec_state_t state, state_nxt;
    logic       push;
    kbd_evt_t   wevt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_last && !frame_ok) begin
            state_nxt = IDLE;
        end else if (frame_ok) begin
            case (state)
                IDLE:    state_nxt = (rx_byte == 8'hE0) ? EXT :
                                     (rx_byte == 8'hF0) ? BRK : IDLE;
                EXT:     state_nxt = (rx_byte == 8'hE0) ? EXT :
                                     (rx_byte == 8'hF0) ? EXTBRK : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // In BRK/EXTBRK any byte, prefixes included, is taken as the code
    always_comb begin
        push     = 1'b0;
        wevt.ext = (state == EXT) || (state == EXTBRK);
        wevt.brk = (state == BRK) || (state == EXTBRK);
        wevt.code = rx_byte;
        if (frame_ok) begin
            case (state)
                IDLE, EXT: push = (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
                default:   push = 1'b1;
            endcase
        end
    end

    kbd_evt_t      mem [FIFO_DEPTH];
    kbd_evt_t      head_q;
    logic [AW:0]   wr_ptr, rd_ptr, rd_nxt;
    logic          empty, full, pop_ok, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = ~nextdata_n & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wevt;
    end

    // Head register bypasses the write so a push into an empty FIFO shows next cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_q    <= '0;
            overflow  <= 1'b0;
            key_count <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            head_q <= (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? wevt : mem[rd_nxt[AW-1:0]];
            if (drop)        overflow <= 1'b1;
            else if (pop_ok) overflow <= 1'b0;
            if (push_ok && !wevt.brk) key_count <= key_count + 1'b1;
        end
    end

    assign data  = head_q.code;
    assign ext   = head_q.ext;
    assign brk   = head_q.brk;
    assign ready = ~empty;
endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Bench for ps2_kbd_event_rx: directed scenarios then random traffic, compared
// against a queue-based event model with prefix flags.
module tb_ps2_kbd_event_rx;
    localparam int DEPTH = 8;
    localparam int TOUT  = 200;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          clrn, ps2_clk, ps2_data, nextdata_n;
    logic [7:0]    data;
    logic          ext, brk, ready, overflow, frame_err;
    logic [CW-1:0] key_count;

    ps2_kbd_event_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYC(TOUT), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ext(ext), .brk(brk), .ready(ready),
        .overflow(overflow), .frame_err(frame_err), .key_count(key_count)
    );

    always #5 clk = ~clk;

    int errcnt = 0;
    always @(posedge clk) if (frame_err) errcnt <= errcnt + 1;

    int checks = 0, failures = 0;

    // Reference model: event queue plus pending prefix flags
    logic [9:0] q[$];
    bit         m_ext, m_brk, m_ovf;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 0; m_brk = 0;
        end else if (!m_brk && b == 8'hE0) begin
            m_ext = 1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (q.size() < DEPTH) begin
                q.push_back({m_ext, m_brk, b});
                if (!m_brk) m_cnt++;
            end else begin
                m_ovf = 1;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v; tick(4);
        ps2_clk = 1'b0; tick(8);
        ps2_clk = 1'b1; tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(fr[i]);
        ps2_data = 1'b1;
        tick(4);
        model_byte(b, !bad);
    endtask

    task automatic pop();
        nextdata_n = 1'b0; tick(1);
        nextdata_n = 1'b1; tick(1);
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 0;
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".ready"}, ready, q.size() != 0);
        if (q.size() != 0) begin
            check({tag, ".data"}, data, q[0][7:0]);
            check({tag, ".ext"}, ext, q[0][9]);
            check({tag, ".brk"}, brk, q[0][8]);
        end
        check({tag, ".ovf"}, overflow, m_ovf);
        check({tag, ".cnt"}, key_count, m_cnt[CW-1:0]);
        tick(1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
            pop();
            check_state(tag);
        end
        check({tag, ".empty"}, ready, 1'b0);
    endtask

    initial begin
        int e0;
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        model_reset();
        tick(3);
        @(negedge clk);
        check("rst.ready", ready, 1'b0);
        check("rst.head", {ext, brk, data}, 10'h0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.ferr", frame_err, 1'b0);
        check("rst.cnt", key_count, 0);
        clrn = 1'b1;
        tick(5);

        // 1: single make
        send_byte(8'h1C, 0);
        check_state("t1");
        check("t1.code", {ext, brk, data}, 10'h01C);
        check("t1.cnt1", key_count, 1);

        // 2: break of A behind the make
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check_state("t2a");
        pop();
        check_state("t2b");
        check("t2.brk", {ext, brk, data}, 10'h11C);
        pop();
        check_state("t2c");
        check("t2.cnt", key_count, 1);

        // 3: extended break collapses to one entry
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        check_state("t3");
        check("t3.code", {ext, brk, data}, 10'h375);
        check("t3.size", q.size(), 1);
        pop();
        check_state("t3e");

        // 4: parity error, then good frame
        e0 = errcnt;
        send_byte(8'h1C, 1);
        check_state("t4a");
        check("t4.ferr1", errcnt - e0, 1);
        send_byte(8'h32, 0);
        check_state("t4b");
        check("t4.code", data, 8'h32);
        pop();

        // 5: overflow
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h15 + 8'(i), 0);
        check_state("t5a");
        check("t5.ovf", overflow, 1'b1);
        check("t5.head", data, 8'h15);
        pop();
        check_state("t5b");
        check("t5.ovfclr", overflow, 1'b0);
        drain("t5d");

        // 6: aborted partial frame recovered by timeout
        e0 = errcnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        tick(TOUT + 10);
        send_byte(8'h29, 0);
        check_state("t6");
        check("t6.code", data, 8'h29);
        check("t6.noerr", errcnt - e0, 0);
        pop();

        // Random traffic
        for (int it = 0; it < 50; it++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 30 && q.size() > 0) begin
                pop();
            end else begin
                b = 8'($urandom_range(1, 8'hDF));
                r = int'($urandom_range(0, 99));
                if (r < 15)      send_byte(8'hE0, 0);
                else if (r < 30) send_byte(8'hF0, 0);
                else if (r < 40) begin send_byte(8'hE0, 0); send_byte(8'hF0, 0); end
                send_byte(b, ($urandom_range(0, 9) == 0));
            end
            check_state("rnd");
        end
        drain("rndd");

        // Reset mid-frame flushes FIFO and partial frame
        send_byte(8'h44, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        clrn = 1'b0;
        model_reset();
        tick(2);
        @(negedge clk);
        check("mrst.ready", ready, 1'b0);
        check("mrst.cnt", key_count, 0);
        clrn = 1'b1;
        tick(3);
        send_byte(8'h4D, 0);
        check_state("mrst2");
        check("mrst.code", data, 8'h4D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
